timer_sched: RTL

//   Shares one `timer` instance between NumReq requesters. Each requester posts a delay count.
//   A round-robin arbiter grants one request at a time and loads that count into the timer.

---
 rtl/timer_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/timer_sched.sv
// Round-robin scheduler that shares one delay timer between NumReq requesters.
// Optional RUN-state watchdog is enabled by defining TIMER_SCHED_WDOG_EN.
module timer_sched #(
   parameter int NumReq     = 4,
   parameter int CNT_WIDTH  = 4,
   parameter int WdogCycles = 64
) (
   input  logic                          i_clk,
   input  logic                          i_rst_sync_n,
   input  logic [NumReq-1:0]             i_req_valid,
   input  logic [NumReq*CNT_WIDTH-1:0]   i_req_cnt,
   output logic [NumReq-1:0]             o_req_ready,
   output logic [NumReq-1:0]             o_done,
   output logic                          o_err,
   output logic                          o_busy,
   output logic [CNT_WIDTH-1:0]          o_tmr_cnt,
   output logic                          o_tmr_update,
   input  logic                          i_tmr_done
);

   localparam int IdxW = $clog2(NumReq);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_e;

   state_e               state_q, state_d;
   logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0]      grant_idx;
   logic                 grant_found;
   logic                 wdog_fire;
   logic [CNT_WIDTH-1:0] req_cnt [NumReq];

   genvar gi;
   for (gi = 0; gi < NumReq; gi++) begin : g_unpack
      assign req_cnt[gi] = i_req_cnt[gi*CNT_WIDTH +: CNT_WIDTH];
   end

   // Walk offsets from far to near so the candidate closest to rr_ptr wins.
   always_comb begin : grant_search
      logic [IdxW:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
         if (cand >= (IdxW+1)'(NumReq)) begin
            cand = cand - (IdxW+1)'(NumReq);
         end
         if (i_req_valid[cand[IdxW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[IdxW-1:0];
         end
      end
   end

`ifdef TIMER_SCHED_WDOG_EN
   localparam int WdW = $clog2(WdogCycles + 1);

   logic [WdW-1:0] wdog_q, wdog_d;
   logic           err_q, err_d;

   // Fires on the RUN cycle whose increment would bring the count to WdogCycles.
   assign wdog_fire = (state_q == ST_RUN) && !i_tmr_done &&
                      (wdog_q == WdW'(WdogCycles - 1));

   always_comb begin
      wdog_d = wdog_q;
      err_d  = err_q;
      case (state_q)
         ST_IDLE: err_d = 1'b0;
         ST_LOAD: begin
            wdog_d = '0;
            err_d  = 1'b0;
         end
         ST_RUN: begin
            wdog_d = wdog_q + 1'b1;
            err_d  = wdog_fire;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_sync_n) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end

   assign o_err = (state_q == ST_DONE) && err_q;
`else
   assign wdog_fire = 1'b0;
   assign o_err     = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      o_req_ready  = '0;
      o_done       = '0;
      o_busy       = (state_q != ST_IDLE);
      o_tmr_cnt    = '0;
      o_tmr_update = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_found && i_rst_sync_n) begin
               o_req_ready[grant_idx] = 1'b1;
               idx_d   = grant_idx;
               cnt_d   = req_cnt[grant_idx];
               // A zero delay skips the timer entirely.
               state_d = (req_cnt[grant_idx] == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            o_tmr_update = 1'b1;
            o_tmr_cnt    = cnt_q;
            state_d      = ST_RUN;
         end
         ST_RUN: begin
            o_tmr_cnt = cnt_q;
            if (i_tmr_done || wdog_fire) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            o_done[idx_q] = 1'b1;
            rr_ptr_d = (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_sync_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
